// File: rtl/spi_rx_axi_slave.sv
// 3-wire SPI receiver (CEB/SCLK/DATA, MSB first) feeding a receive FIFO, exposed
// to the bus as an AXI4-lite slave with RXDATA, STATUS and CTRL word registers.
module spi_rx_axi_slave #(
  parameter int sword      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CEB,
  input  logic             SCLK,
  input  logic             DATA,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [sword-1:0] axi_awaddr,
  input  logic [2:0]       axi_awprot,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  input  logic [sword-1:0] axi_wdata,
  input  logic [3:0]       axi_wstrb,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  input  logic [sword-1:0] axi_araddr,
  input  logic [2:0]       axi_arprot,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [sword-1:0] axi_rdata,
  output logic             irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    REG_RXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_NONE   = 2'd3
  } reg_addr_t;

  logic             r_ceb_s1, r_ceb_s2, r_ceb_prev;
  logic             r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic             r_data_s1, r_data_s2;
  logic [sword-1:0] r_shift;
  logic [4:0]       r_bit_cnt;
  logic [sword-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf, r_ferr, r_en, r_ie;
  logic             r_bvalid, r_rvalid;
  logic [sword-1:0] r_rdata;

  logic             w_sclk_rise, w_ceb_rise;
  logic             w_push_req, w_push, w_pop, w_flush;
  logic             w_empty, w_full;
  logic             w_ovf_set, w_ferr_set, w_clr_ovf, w_clr_ferr;
  logic             w_wr_en, w_rd_en;
  reg_addr_t        w_wr_addr, w_rd_addr;
  logic [sword-1:0] w_push_word, w_status, w_rd_data;
  logic             w_unused_inputs;

  assign w_unused_inputs = ^{axi_awprot, axi_arprot, axi_wstrb,
                             axi_awaddr[sword-1:2], axi_araddr[sword-1:2],
                             axi_wdata[sword-1:4]};

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_prev;
  assign w_ceb_rise  = r_ceb_s2 & ~r_ceb_prev;
  assign w_push_word = {r_shift[sword-2:0], r_data_s2};
  assign w_push_req  = r_en & ~r_ceb_s2 & w_sclk_rise & (r_bit_cnt == 5'd31);

  // Ready is combinational so a write/read is accepted in the very cycle it is offered.
  assign w_wr_en   = axi_awvalid & axi_wvalid & ~r_bvalid & ~RST;
  assign w_rd_en   = axi_arvalid & ~r_rvalid & ~RST;
  assign w_wr_addr = reg_addr_t'(axi_awaddr[1:0]);
  assign w_rd_addr = reg_addr_t'(axi_araddr[1:0]);

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_pop      = w_rd_en & (w_rd_addr == REG_RXDATA) & ~w_empty;
  assign w_flush    = w_wr_en & (w_wr_addr == REG_CTRL) & axi_wdata[2];
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign w_push     = w_push_req & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_set  = w_push_req & w_full & ~w_pop & ~w_flush;
  assign w_ferr_set = r_en & w_ceb_rise & (r_bit_cnt != 5'd0);
  assign w_clr_ovf  = w_wr_en & (w_wr_addr == REG_STATUS) & axi_wdata[2];
  assign w_clr_ferr = w_wr_en & (w_wr_addr == REG_STATUS) & axi_wdata[3];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_status      = '0;
    w_status[0]   = w_empty;
    w_status[1]   = w_full;
    w_status[2]   = r_ovf;
    w_status[3]   = r_ferr;
    w_status[7:4] = 4'(r_level);
  end

  always_comb begin
    w_rd_data = '0;
    case (w_rd_addr)
      REG_RXDATA: w_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
      REG_STATUS: w_rd_data = w_status;
      REG_CTRL:   w_rd_data = sword'({r_ie, r_en});
      default:    w_rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ceb_s1    <= 1'b1;
      r_ceb_s2    <= 1'b1;
      r_ceb_prev  <= 1'b1;
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_data_s1   <= 1'b0;
      r_data_s2   <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_ceb_s1    <= CEB;
      r_ceb_s2    <= r_ceb_s1;
      r_ceb_prev  <= r_ceb_s2;
      r_sclk_s1   <= SCLK;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_data_s1   <= DATA;
      r_data_s2   <= r_data_s1;
      if (!r_en) begin
        r_bit_cnt <= '0;
      end else if (w_ceb_rise) begin
        r_bit_cnt <= '0;
      end else if (!r_ceb_s2 && w_sclk_rise) begin
        r_shift   <= w_push_word;
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the level and pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
      r_en     <= 1'b1;
      r_ie     <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
      // A new event in the same cycle as a W1C keeps the flag set.
      r_ovf  <= (r_ovf & ~w_clr_ovf) | w_ovf_set;
      r_ferr <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
      if (w_wr_en && w_wr_addr == REG_CTRL) begin
        r_en <= axi_wdata[0];
        r_ie <= axi_wdata[1];
      end
      if (w_wr_en)         r_bvalid <= 1'b1;
      else if (axi_bready) r_bvalid <= 1'b0;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi_awready = w_wr_en;
  assign axi_wready  = w_wr_en;
  assign axi_arready = w_rd_en;
  assign axi_bvalid  = r_bvalid;
  assign axi_rvalid  = r_rvalid;
  assign axi_rdata   = r_rdata;
  assign irq         = (~w_empty & r_ie) | r_ovf | r_ferr;

endmodule

// File: tb/tb_spi_rx_axi_slave.sv
// Self-checking bench for spi_rx_axi_slave: directed and random SPI frames and AXI
// accesses compared against a queue-based model of the receive FIFO and flags.
module tb_spi_rx_axi_slave;

  logic        CLK = 1'b0;
  logic        RST, CEB, SCLK, DATA;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, irq;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;

  spi_rx_axi_slave #(.sword(32), .DEPTH_LOG2(3)) dut (
    .CLK(CLK), .RST(RST), .CEB(CEB), .SCLK(SCLK), .DATA(DATA),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rdata(axi_rdata), .irq(irq)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fails = 0;

  // Reference model: the FIFO is just a queue, flags are plain bits.
  logic [31:0] m_q[$];
  bit m_ovf, m_ferr, m_en, m_ie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (m_q.size() == 0);
    s[1]   = (m_q.size() == 8);
    s[2]   = m_ovf;
    s[3]   = m_ferr;
    s[7:4] = 4'(m_q.size());
    return s;
  endfunction

  function automatic logic m_irq();
    return ((m_q.size() != 0) && m_ie) || m_ovf || m_ferr;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ovf = 0; m_ferr = 0; m_en = 1; m_ie = 0;
  endfunction

  function automatic void m_push(input logic [31:0] w);
    if (!m_en) return;
    if (m_q.size() == 8) m_ovf = 1;
    else m_q.push_back(w);
  endfunction

  function automatic logic [31:0] m_pop();
    if (m_q.size() == 0) return 32'h0;
    return m_q.pop_front();
  endfunction

  // One SCLK period is 8 CLK cycles; the bit is presented while SCLK is low.
  task automatic spi_bit(input logic b);
    @(negedge CLK); DATA = b; SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic ceb_low();
    @(negedge CLK); CEB = 1'b0; SCLK = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic ceb_high(input int pending_bits);
    @(negedge CLK); SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    CEB = 1'b1;
    repeat (8) @(negedge CLK);
    if (m_en && pending_bits != 0) m_ferr = 1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) spi_bit(w[31-i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
    m_push(w);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge CLK);
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = addr; axi_wdata = data;
    axi_bready = 1'b1;
    #1;
    n = 0;
    while (!axi_awready && n < 20) begin @(negedge CLK); #1; n++; end
    check("wr_accept", {31'b0, axi_awready}, 32'h1);
    @(posedge CLK); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(posedge CLK); #1;
    axi_bready = 1'b0;
    case (addr[1:0])
      2'd1: begin
        if (data[2]) m_ovf = 0;
        if (data[3]) m_ferr = 0;
      end
      2'd2: begin
        m_en = data[0];
        m_ie = data[1];
        if (data[2]) m_q.delete();
      end
      default: ;
    endcase
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int n;
    @(negedge CLK);
    axi_arvalid = 1'b1; axi_araddr = addr; axi_rready = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < 20) begin @(negedge CLK); #1; n++; end
    check({tag, "_arready"}, {31'b0, axi_arready}, 32'h1);
    @(posedge CLK); #1;
    axi_arvalid = 1'b0;
    @(negedge CLK);
    check(tag, axi_rdata, exp);
    @(posedge CLK); #1;
    axi_rready = 1'b0;
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] e;
    e = m_pop();
    rd_check(tag, 32'd0, e);
  endtask

  initial begin
    logic [31:0] w, e;
    int nw, np, nr;

    RST = 1'b1; CEB = 1'b1; SCLK = 1'b0; DATA = 1'b0;
    axi_awvalid = 0; axi_wvalid = 0; axi_awaddr = 0; axi_wdata = 0; axi_awprot = 0;
    axi_wstrb = 4'hF; axi_bready = 0; axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0;
    axi_rready = 0;
    m_reset();
    repeat (3) @(negedge CLK);
    check("rst_bvalid", {31'b0, axi_bvalid}, 32'h0);
    check("rst_rvalid", {31'b0, axi_rvalid}, 32'h0);
    check("rst_rdata", axi_rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    RST = 1'b0;
    rd_check("rst_status", 32'd1, 32'h1);
    rd_check("rst_ctrl", 32'd2, 32'h1);

    // Single known word
    ceb_low(); send_word(32'hA5A5_1234); ceb_high(0);
    rd_rx("word_a5a5");
    rd_check("status_after_a5a5", 32'd1, m_status());

    // Nine words into an eight-deep FIFO
    ceb_low();
    for (int i = 1; i <= 9; i++) send_word(32'(i));
    ceb_high(0);
    rd_check("status_overflow", 32'd1, m_status());
    check("irq_ovf", {31'b0, irq}, {31'b0, m_irq()});
    for (int i = 0; i < 8; i++) rd_rx("drain_ovf");
    rd_check("status_drained", 32'd1, m_status());
    axi_write(32'd1, 32'h4);
    rd_check("status_ovf_clr", 32'd1, m_status());

    // Partial frame then a clean word
    ceb_low(); send_bits($urandom, 12); ceb_high(12);
    rd_check("status_ferr", 32'd1, m_status());
    axi_write(32'd1, 32'h8);
    rd_check("status_ferr_clr", 32'd1, m_status());
    w = $urandom;
    ceb_low(); send_word(w); ceb_high(0);
    rd_rx("word_after_ferr");

    // Full FIFO: pop lands in the same cycle as the 32nd-bit push
    ceb_low();
    for (int i = 0; i < 8; i++) send_word($urandom);
    w = $urandom;
    send_bits(w, 31);
    @(negedge CLK); DATA = w[0]; SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    axi_araddr = 32'd0; axi_arvalid = 1'b1; axi_rready = 1'b0;
    #1;
    check("coinc_arready", {31'b0, axi_arready}, 32'h1);
    @(posedge CLK); #1;
    axi_arvalid = 1'b0;
    e = m_q.pop_front();
    m_q.push_back(w);
    axi_rready = 1'b1;
    @(negedge CLK);
    check("coinc_rdata", axi_rdata, e);
    @(posedge CLK); #1;
    axi_rready = 1'b0;
    ceb_high(0);
    rd_check("status_coinc", 32'd1, m_status());
    for (int i = 0; i < 8; i++) rd_rx("drain_coinc");

    // Write handshake: address early, then held response
    @(negedge CLK);
    axi_awvalid = 1'b1; axi_awaddr = 32'd2; axi_wdata = 32'h3; axi_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("aw_only_awready", {31'b0, axi_awready}, 32'h0);
      check("aw_only_wready", {31'b0, axi_wready}, 32'h0);
      @(negedge CLK);
    end
    axi_wvalid = 1'b1;
    #1;
    check("both_awready", {31'b0, axi_awready}, 32'h1);
    check("both_wready", {31'b0, axi_wready}, 32'h1);
    @(posedge CLK); #1;
    axi_wdata = 32'h1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bvalid_hold", {31'b0, axi_bvalid}, 32'h1);
      check("no_second_write", {31'b0, axi_awready}, 32'h0);
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
    @(posedge CLK); #1;
    axi_bready = 1'b0;
    @(negedge CLK);
    check("bvalid_done", {31'b0, axi_bvalid}, 32'h0);
    m_en = 1; m_ie = 1;
    rd_check("ctrl_after_hs", 32'd2, 32'h3);

    // Interrupt on data, read with rready held low
    ceb_low(); send_word($urandom); ceb_high(0);
    check("irq_data", {31'b0, irq}, {31'b0, m_irq()});
    @(negedge CLK);
    axi_arvalid = 1'b1; axi_araddr = 32'd0; axi_rready = 1'b0;
    #1;
    check("hold_arready", {31'b0, axi_arready}, 32'h1);
    e = m_pop();
    @(posedge CLK); #1;
    axi_arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("rvalid_hold", {31'b0, axi_rvalid}, 32'h1);
      check("rdata_hold", axi_rdata, e);
    end
    axi_rready = 1'b1;
    @(posedge CLK); #1;
    axi_rready = 1'b0;
    @(negedge CLK);
    check("rvalid_done", {31'b0, axi_rvalid}, 32'h0);
    check("irq_cleared", {31'b0, irq}, {31'b0, m_irq()});

    // Receiver disabled: frames and partials are ignored
    axi_write(32'd2, 32'h0);
    ceb_low(); send_word($urandom); send_bits($urandom, 7); ceb_high(7);
    rd_check("status_disabled", 32'd1, m_status());
    axi_write(32'd2, 32'h1);

    // Flush
    ceb_low();
    for (int i = 0; i < 3; i++) send_word($urandom);
    ceb_high(0);
    rd_check("status_before_flush", 32'd1, m_status());
    axi_write(32'd2, 32'h5);
    rd_check("status_after_flush", 32'd1, m_status());
    rd_check("ctrl_after_flush", 32'd2, 32'h1);

    // Random frames, partials and reads
    for (int it = 0; it < 8; it++) begin
      nw = $urandom_range(0, 3);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0;
      ceb_low();
      for (int i = 0; i < nw; i++) send_word($urandom);
      send_bits($urandom, np);
      ceb_high(np);
      nr = $urandom_range(0, 3);
      for (int i = 0; i < nr; i++) rd_rx("rand_rx");
      rd_check("rand_status", 32'd1, m_status());
      check("rand_irq", {31'b0, irq}, {31'b0, m_irq()});
      if (m_ovf || m_ferr) axi_write(32'd1, 32'hC);
    end

    // Reset mid-frame and mid-handshake
    axi_write(32'd2, 32'h3);
    ceb_low(); send_word($urandom); send_word($urandom); send_bits($urandom, 10);
    @(negedge CLK);
    RST = 1'b1; CEB = 1'b1; SCLK = 1'b0;
    axi_arvalid = 1'b1; axi_araddr = 32'd1;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 32'd2; axi_wdata = 32'h0;
    @(negedge CLK);
    check("mid_rst_awready", {31'b0, axi_awready}, 32'h0);
    check("mid_rst_wready", {31'b0, axi_wready}, 32'h0);
    check("mid_rst_arready", {31'b0, axi_arready}, 32'h0);
    check("mid_rst_bvalid", {31'b0, axi_bvalid}, 32'h0);
    check("mid_rst_rvalid", {31'b0, axi_rvalid}, 32'h0);
    check("mid_rst_rdata", axi_rdata, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    RST = 1'b0;
    m_reset();
    rd_check("status_after_rst", 32'd1, m_status());
    rd_check("ctrl_after_rst", 32'd2, 32'h1);
    w = $urandom;
    ceb_low(); send_word(w); ceb_high(0);
    rd_rx("word_after_rst");
    rd_check("status_final", 32'd1, m_status());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
